// File: rtl/axis_stream_tx.sv
// AXI4-Stream source: a DEPTH-entry FWFT buffer drains words from an internal write port to a Sink.
// Every output comes from a register, so there is no combinational path from i_wr_* or i_tready to any output.
module axis_stream_tx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_en,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]    i_wr_keep,
  input  logic                       i_wr_last,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic [DATA_WIDTH-1:0]      o_tdata,
  output logic [DATA_WIDTH/8-1:0]    o_tkeep,
  output logic [DATA_WIDTH/8-1:0]    o_tstrb,
  output logic                       o_tlast,
  output logic [31:0]                o_pkts_sent
);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $fatal(1, "axis_stream_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "axis_stream_tx: DEPTH must be a power of two >= 2");
  end

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [KW-1:0]         r_mem_keep [DEPTH];
  logic [DEPTH-1:0]      r_mem_last;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_overflow;
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]         r_tkeep;
  logic                  r_tlast;
  logic [31:0]           r_pkts_sent;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_bypass;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [KW-1:0]         w_head_keep;
  logic                  w_head_last;

  assign w_pop        = r_tvalid & i_tready;
  assign w_push       = i_wr_en & (~r_full | w_pop);
  assign w_drop       = i_wr_en & r_full & ~w_pop;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  // Incoming word lands directly in the head slot when the buffer is (or becomes) one deep.
  assign w_bypass     = w_push & (r_wr_ptr == w_rd_ptr_nxt);

  // Next head entry, precomputed so the stream outputs can be registered.
  always_comb begin
    w_head_valid = (w_count_nxt != '0);
    w_head_data  = '0;
    w_head_keep  = '0;
    w_head_last  = 1'b0;
    if (w_head_valid) begin
      if (w_bypass) begin
        w_head_data = i_wr_data;
        w_head_keep = i_wr_keep;
        w_head_last = i_wr_last;
      end else begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_keep = r_mem_keep[w_rd_ptr_nxt];
        w_head_last = r_mem_last[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= i_wr_data;
      r_mem_keep[r_wr_ptr] <= i_wr_keep;
      r_mem_last[r_wr_ptr] <= i_wr_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_pkts_sent <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      if (w_drop) r_overflow <= 1'b1;
      r_tvalid <= w_head_valid;
      r_tdata  <= w_head_data;
      r_tkeep  <= w_head_keep;
      r_tlast  <= w_head_last;
      if (w_pop && r_tlast) r_pkts_sent <= r_pkts_sent + 32'd1;
    end
  end

  assign o_full      = r_full;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_tvalid    = r_tvalid;
  assign o_tdata     = r_tdata;
  assign o_tkeep     = r_tkeep;
  assign o_tstrb     = r_tkeep;
  assign o_tlast     = r_tlast;
  assign o_pkts_sent = r_pkts_sent;

endmodule

// File: tb/tb_axis_stream_tx.sv
// Bench for axis_stream_tx: random traffic checked cycle by cycle against a queue model of the stream buffer.
module tb_axis_stream_tx;
  localparam int unsigned DW    = 64;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned VW    = 1 + DW + KW + KW + 1 + CW + 1 + 1 + 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk;
  logic          i_rst;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic [KW-1:0] i_wr_keep;
  logic          i_wr_last;
  logic          i_tready;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_tvalid;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic [KW-1:0] o_tstrb;
  logic          o_tlast;
  logic [31:0]   o_pkts_sent;

  axis_stream_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_wr_keep(i_wr_keep), .i_wr_last(i_wr_last), .o_full(o_full), .o_count(o_count),
    .o_overflow(o_overflow), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
    .o_tkeep(o_tkeep), .o_tstrb(o_tstrb), .o_tlast(o_tlast), .o_pkts_sent(o_pkts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  beat_t       mq[$];
  beat_t       rx[$];
  logic        m_ovf;
  logic [31:0] m_pkts;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] dut_vec;

  assign dut_vec = {o_tvalid, o_tdata, o_tkeep, o_tstrb, o_tlast, o_count, o_full, o_overflow, o_pkts_sent};

  // One clock: drive inputs, advance the model at the edge, and watch the stall rule.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic tr);
    beat_t b;
    logic pop, push, full_now, pv;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic pl;
    i_wr_en = we; i_wr_data = d; i_wr_keep = k; i_wr_last = l; i_tready = tr;
    pv = (o_tvalid === 1'b1) && !tr && !i_rst;
    pd = o_tdata; pk = o_tkeep; pl = o_tlast;
    if (o_tvalid === 1'b1 && tr && !i_rst) begin
      b.d = o_tdata; b.k = o_tkeep; b.l = o_tlast;
      rx.push_back(b);
    end
    @(posedge clk);
    if (i_rst) begin
      mq.delete(); m_ovf = 1'b0; m_pkts = '0;
    end else begin
      pop      = (mq.size() != 0) && tr;
      full_now = (mq.size() == DEPTH);
      push     = we && (!full_now || pop);
      if (we && !push) m_ovf = 1'b1;
      if (pop) begin
        if (mq[0].l) m_pkts = m_pkts + 32'd1;
        void'(mq.pop_front());
      end
      if (push) begin
        b.d = d; b.k = k; b.l = l;
        mq.push_back(b);
      end
    end
    if (mq.size() != 0)
      exp_vec = {1'b1, mq[0].d, mq[0].k, mq[0].k, mq[0].l, CW'(mq.size()),
                 (mq.size() == DEPTH), m_ovf, m_pkts};
    else
      exp_vec = {1'b0, DW'(0), KW'(0), KW'(0), 1'b0, CW'(0), 1'b0, m_ovf, m_pkts};
    #1;
    if (pv) begin
      n_checks++;
      if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tkeep !== pk || o_tlast !== pl) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                 o_tvalid, o_tdata, o_tkeep, o_tlast, pd, pk, pl);
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    step(0, '0, '0, 0, 0);
    step(0, '0, '0, 0, 0);
    i_rst = 1'b0;
    n_checks++;
    if (dut_vec !== '0) begin
      n_err++;
      $display("FAIL reset_values: got %h required all zero", dut_vec);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, '0, '0, 0, 1'($urandom()));
      n_checks++;
      if (o_tvalid !== 1'b0 || dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL idle_cycle%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] words [4];
    words[0] = 64'h11; words[1] = 64'h22; words[2] = 64'h33; words[3] = 64'h44;
    rx.delete();
    for (int i = 0; i < 4; i++) begin
      step(1, words[i], 8'hFF, (i == 3), 1);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL single_cycle%0d: got %h required %h", i, dut_vec, exp_vec);
      end
      if (i == 0) begin
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 64'h11) begin
          n_err++;
          $display("FAIL single_latency: got v=%b d=%h required v=1 d=11", o_tvalid, o_tdata);
        end
      end
    end
    for (int i = 0; i < 8 && o_tvalid === 1'b1; i++) step(0, '0, '0, 0, 1);
    n_checks++;
    if (o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain_timeout: got tvalid=%b required 0", o_tvalid);
    end
    n_checks++;
    if (rx.size() != 4) begin
      n_err++;
      $display("FAIL single_beats: got %0d beats required 4", rx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx[i].d !== words[i] || rx[i].l !== (i == 3) || rx[i].k !== 8'hFF) begin
          n_err++;
          $display("FAIL single_beat%0d: got d=%h l=%b k=%h required d=%h l=%b k=ff",
                   i, rx[i].d, rx[i].l, rx[i].k, words[i], (i == 3));
        end
      end
    end
    n_checks++;
    if (o_pkts_sent !== 32'd1) begin
      n_err++;
      $display("FAIL single_pkts: got %0d required 1", o_pkts_sent);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [3];
    rx.delete();
    for (int i = 0; i < 3; i++) begin
      w[i] = rnd_data();
      step(1, w[i], KW'($urandom()), (i == 2), 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, '0, '0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec || o_tdata !== w[0]) begin
        n_err++;
        $display("FAIL bp_stall%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
    for (int i = 0; i < 60 && (mq.size() != 0 || o_tvalid === 1'b1); i++) begin
      step(0, '0, '0, 0, 1'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL bp_cycle%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
    n_checks++;
    if (rx.size() != 3) begin
      n_err++;
      $display("FAIL bp_beats: got %0d beats required 3", rx.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx[i].d !== w[i]) begin
          n_err++;
          $display("FAIL bp_beat%0d: got %h required %h", i, rx[i].d, w[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w [17];
    rx.delete();
    for (int i = 0; i < 17; i++) begin
      w[i] = rnd_data();
      step(1, w[i], KW'($urandom()), 1'($urandom()), 0);
      if (i == 15) begin
        n_checks++;
        if (o_full !== 1'b1 || o_count !== CW'(16) || o_overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_full: got full=%b count=%0d ovf=%b required 1 16 0",
                   o_full, o_count, o_overflow);
        end
      end
    end
    n_checks++;
    if (o_overflow !== 1'b1 || o_count !== CW'(16) || dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL ovf_drop: got ovf=%b count=%0d required 1 16", o_overflow, o_count);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, '0, '0, 0, 1);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
    n_checks++;
    if (rx.size() != 16 || o_overflow !== 1'b1 || o_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_after: got beats=%0d ovf=%b v=%b required 16 1 0", rx.size(), o_overflow, o_tvalid);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (rx[i].d !== w[i]) begin
          n_err++;
          $display("FAIL ovf_beat%0d: got %h required %h", i, rx[i].d, w[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] w [17];
    i_rst = 1'b1;
    step(0, '0, '0, 0, 0);
    i_rst = 1'b0;
    rx.delete();
    for (int i = 0; i < 16; i++) begin
      w[i] = rnd_data();
      step(1, w[i], KW'($urandom()), 1'($urandom()), 0);
    end
    w[16] = rnd_data();
    step(1, w[16], KW'($urandom()), 1, 1);
    n_checks++;
    if (o_count !== CW'(16) || o_full !== 1'b1 || o_overflow !== 1'b0 || dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL fullpop_accept: got count=%0d full=%b ovf=%b required 16 1 0",
               o_count, o_full, o_overflow);
    end
    for (int i = 0; i < 20 && o_tvalid === 1'b1; i++) begin
      step(0, '0, '0, 0, 1);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL fullpop_drain%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
    n_checks++;
    if (rx.size() != 17) begin
      n_err++;
      $display("FAIL fullpop_beats: got %0d required 17", rx.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        n_checks++;
        if (rx[i].d !== w[i]) begin
          n_err++;
          $display("FAIL fullpop_beat%0d: got %h required %h", i, rx[i].d, w[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [DW-1:0] w [3];
    for (int i = 0; i < 40; i++) begin
      step(1, rnd_data(), KW'($urandom()), ($urandom_range(3) == 0), 1'($urandom()));
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL wrap_cycle%0d: got %h required %h", i, dut_vec, exp_vec);
      end
    end
    for (int i = 0; i < 20 && mq.size() > 5; i++) step(0, '0, '0, 0, 1);
    for (int i = 0; i < 20 && mq.size() < 5; i++) step(1, rnd_data(), KW'($urandom()), 0, 0);
    n_checks++;
    if (o_count !== CW'(5) || dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL wrap_level: got count=%0d required 5", o_count);
    end
    i_rst = 1'b1;
    step(0, '0, '0, 0, 1'($urandom()));
    i_rst = 1'b0;
    n_checks++;
    if (o_tvalid !== 1'b0 || o_count !== '0 || o_pkts_sent !== '0 || dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL midpkt_reset: got v=%b count=%0d pkts=%0d required 0 0 0",
               o_tvalid, o_count, o_pkts_sent);
    end
    rx.delete();
    for (int i = 0; i < 3; i++) begin
      w[i] = rnd_data();
      step(1, w[i], 8'hFF, (i == 2), 1);
    end
    for (int i = 0; i < 8 && o_tvalid === 1'b1; i++) step(0, '0, '0, 0, 1);
    n_checks++;
    if (rx.size() != 3 || o_pkts_sent !== 32'd1 || dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL fresh_pkt: got beats=%0d pkts=%0d required 3 1", rx.size(), o_pkts_sent);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx[i].d !== w[i] || rx[i].l !== (i == 2)) begin
          n_err++;
          $display("FAIL fresh_beat%0d: got d=%h l=%b required d=%h l=%b",
                   i, rx[i].d, rx[i].l, w[i], (i == 2));
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_wr_keep = '0; i_wr_last = 1'b0; i_tready = 1'b0;
    m_ovf = 1'b0; m_pkts = '0; exp_vec = '0;
    test_reset();
    test_single_packet();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_stream_tx.md
# axis_stream_tx

AXI4-Stream transmitter (Source end) for the accelerator's output path: accepts words from an internal write port, buffers them in a DEPTH-entry first-word-fall-through FIFO, and drives tvalid/tdata/tkeep/tstrb/tlast to a downstream Sink. Protocol-compliant by construction: once tvalid rises it holds, with stable payload, until the tready handshake. Also reports occupancy, a sticky overflow flag, and a completed-packet counter for the testbench and host status registers.

## Interface

- DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8 (elaboration-time fatal otherwise).
- DEPTH, 16, FIFO entries; power of two, >= 2 (elaboration-time fatal otherwise).

Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request; push {wr_data, wr_keep, wr_last} this cycle.
- wr_data  in  DATA_WIDTH  word to transmit.
- wr_keep  in  DATA_WIDTH/8  byte qualifiers for the word.
- wr_last  in  1  word ends a packet.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  words currently buffered (0..DEPTH).
- overflow  out  1  sticky; set when a write is dropped.
- tvalid  out  1  AXI4-Stream valid.
- tready  in  1  AXI4-Stream ready from Sink.
- tdata  out  DATA_WIDTH  payload.
- tkeep  out  DATA_WIDTH/8  byte keep.
- tstrb  out  DATA_WIDTH/8  equal to tkeep.
- tlast  out  1  packet boundary.
- pkts_sent  out  32  packets completed (tlast beats accepted).

## Operation

- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register (no pointer-MSB trick needed).
- push = wr_en && (!full || pop); pop = tvalid && tready.
- Write while full with no simultaneous pop: word dropped, pointers/count unchanged, overflow <= 1 (held until rst).
- Write while full with pop in the same cycle: accepted; count stays DEPTH.
- count next = count + push - pop.
- tvalid = (count != 0). tdata/tkeep/tlast = entry at rd_ptr when tvalid; all forced to 0 when tvalid = 0. tstrb = tkeep.
- Payload at rd_ptr cannot change while tvalid && !tready (head entry is never overwritten since count < DEPTH is required for its slot to be written, and rd_ptr only moves on pop).
- pkts_sent increments by 1 on pop && tlast; wraps 2^32-1 -> 0.
- No packet-level logic beyond tlast pass-through; packet lengths of 1 (wr_last on every word) are legal.
- rst mid-packet: buffered words discarded, tvalid drops the following cycle regardless of tready (sole permitted deassertion without handshake).

## Timing

- Reset values: tvalid 0, tdata 0, tkeep 0, tstrb 0, tlast 0, full 0, count 0, overflow 0, pkts_sent 0; pointers 0.
- Write-to-tvalid latency: 1 cycle (write at edge N, tvalid high after edge N; no combinational bypass from wr_* to t*).
- tready-to-next-word: head advances at the handshake edge; back-to-back beats at 1 word/cycle when tready held high and FIFO non-empty.
- Sustained throughput 1 word/cycle with concurrent push and pop at any count, including 0 <-> 1 and DEPTH boundaries.
- full, count, overflow, pkts_sent are registered; updated the cycle after the causing edge.
- No combinational path from tready to any output other than via registered state.

## Test plan

- Reset/idle: assert rst 2 cycles, release -> all outputs 0, tvalid stays 0 with no writes for 10 cycles.
- Single packet: write 4 words 0x11..0x44, wr_last on 4th, tready=1 -> tvalid rises 1 cycle after first write, beats 0x11,0x22,0x33,0x44 in order, tlast only on 0x44, pkts_sent = 1.
- Backpressure: fill 3 words, tready=0 for 5 cycles, then random tready -> tvalid never falls before handshake, tdata stable while stalled, all 3 words delivered in order (interface assertion never fires).
- Full/overflow (DEPTH=16): 17 writes, tready=0 -> full=1 and count=16 after 16th, 17th dropped, overflow=1; drain -> 16 words received, overflow still 1.
- Full with simultaneous pop: count=16, wr_en and tready both high one cycle -> write accepted, count stays 16, overflow stays 0, all 17 words emerge in order.
- Reset mid-packet and wrap: push 40 words with random tready (pointer wrap), assert rst with 5 words buffered -> tvalid 0 next cycle, count 0, pkts_sent 0; fresh packet afterward delivered intact.
